// File: rtl/bus_data_sync_if.sv
// Signal bundle between a foreign-domain bus source and the CLK-domain capture block.
// The source has no ready. It holds unsync_bus stable and raises the bus_enable level.
// The sink answers with a one-cycle enable_pulse in its own clock domain once it has
// captured the bus into sync_bus. bus_enable may then fall.
interface bus_data_sync_if #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic [BUS_WIDTH-1:0] sync_bus;
  logic                 enable_pulse;
  logic [CNT_WIDTH-1:0] xfer_count;

  modport master (
    output unsync_bus, bus_enable,
    input  sync_bus, enable_pulse, xfer_count
  );

  modport slave (
    input  unsync_bus, bus_enable,
    output sync_bus, enable_pulse, xfer_count
  );
endinterface

// File: rtl/bus_data_sync.sv
// Moves a multi-bit bus into the CLK domain. Only the enable qualifier is synchronized.
// The bus is sampled once the rising edge of the synchronized enable is seen.
module bus_data_sync #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8
) (
  input logic            CLK,
  input logic            RST,
  bus_data_sync_if.slave bus
);

  logic [NUM_STAGES-1:0] en_sync;
  logic                  pulse_ff;
  logic                  sync_en;
  logic                  p;
  logic [BUS_WIDTH-1:0]  sync_bus_q;
  logic                  enable_pulse_q;
  logic [CNT_WIDTH-1:0]  xfer_count_q;

  assign sync_en = en_sync[NUM_STAGES-1];
  // The bus is stable by contract when the synchronized enable first rises, so sample it then.
  assign p       = sync_en & ~pulse_ff;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_sync  <= '0;
      pulse_ff <= 1'b0;
    end else begin
      en_sync  <= {en_sync[NUM_STAGES-2:0], bus.bus_enable};
      pulse_ff <= sync_en;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_bus_q     <= '0;
      enable_pulse_q <= 1'b0;
      xfer_count_q   <= '0;
    end else begin
      enable_pulse_q <= p;
      if (p) begin
        sync_bus_q <= bus.unsync_bus;
        if (xfer_count_q != '1) begin
          xfer_count_q <= xfer_count_q + 1'b1;
        end
      end
    end
  end

  assign bus.sync_bus     = sync_bus_q;
  assign bus.enable_pulse = enable_pulse_q;
  assign bus.xfer_count   = xfer_count_q;

endmodule
